multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS sort CPU. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing only the states the opcode needs. It drives the per-state datapath enables, the decoded control lines, and a one-cycle IF strobe that tells the PC to advance. It also keeps instruction and cycle counters for performance readback.

Parameters:
CNT_W, 16, width of instr_cnt and cycle_cnt (saturating)

Ports:
Clk  in  1  system clock, rising edge
Clr  in  1  asynchronous active-high reset
run  in  1  level; 1 = CPU allowed to execute
sortover  in  1  level from PC; 1 = program finished
inst  in  32  instruction word at current PC (valid in FETCH)
IF  out  1  PC-advance strobe, high only in last state of each instruction
Branch  out  1  decoded beq/bne, held DECODE..last state
Jump  out  1  decoded j, held DECODE..last state
IR_en  out  1  instruction register load, high in FETCH
RegDst  out  1  high in WB for R-type
ALUSrc  out  1  high in EXEC/MEM/WB for lw, sw, addi
ALUOp  out  2  00 add (lw/sw/addi), 01 sub (beq/bne), 10 funct (R-type); valid EXEC..WB, else 00
MemRead  out  1  high in MEM for lw
MemWrite  out  1  high in MEM for sw
MemtoReg  out  1  high in WB for lw
RegWrite  out  1  high in WB (R-type, lw, addi)
illegal  out  1  sticky; unknown opcode seen
state  out  3  IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
instr_cnt  out  CNT_W  completed instructions
cycle_cnt  out  CNT_W  cycles spent in FETCH..WB

Behaviour:
- Clr (async): state=IDLE, op_q=0, illegal=0, both counters=0. All outputs are 0 while Clr is high.
- op_q (6 bit) latches inst[31:26] on the clock edge leaving FETCH. Decode uses op_q only.
- Opcodes and state sequences; the last state in each sequence asserts IF:
  - 000000 R-type: FETCH DECODE EXEC WB.
  - 100011 lw: FETCH DECODE EXEC MEM WB.
  - 101011 sw: FETCH DECODE EXEC MEM.
  - 001000 addi: FETCH DECODE EXEC WB.
  - 000100 beq / 000101 bne: FETCH DECODE EXEC.
  - 000010 j: FETCH DECODE.
  - Any other opcode: FETCH DECODE, treated as a nop. illegal is set on the edge leaving DECODE.
- Latency per instruction: R/addi 4, lw 5, sw 4, branch 3, j 2, illegal 2 cycles.
- Transitions:
  - IDLE: run=1 goes to FETCH; otherwise stay.
  - FETCH goes to DECODE unconditionally. Intermediate states advance unconditionally.
  - From the last state: sortover=1 goes to HALT. Else run=0 goes to IDLE. Else go to FETCH.
  - sortover has priority over run.
- run or sortover changing mid-instruction does not abort it. Both are sampled only in the last state (and run in IDLE).
- HALT: all control outputs 0, IF=0. Stays in HALT until Clr.
- Outputs are combinational from state and op_q. IR_en and IF are never high in the same cycle, except the j/illegal DECODE case where IF is in DECODE (still not FETCH).
- Counters:
  - instr_cnt += 1 on every cycle where IF=1.
  - cycle_cnt += 1 every cycle where state is in FETCH..WB.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - Both hold their value in IDLE and HALT.
- Unused state encoding 7 goes to IDLE on the next edge with outputs 0.

Test Plan:
- Reset and idle: Clr pulse with run=0 -> state=0, all outputs 0, counters 0. Hold 10 cycles -> no change.
- R-type: run=1, inst=0x012A4020 -> states 1,2,3,5. ALUOp=10 in EXEC/WB. RegDst=RegWrite=1 and IF=1 only in WB. instr_cnt=1, cycle_cnt=4.
- lw then sw: inst=0x8D090004 then 0xAD090008 -> lw 5 cycles with MemRead in MEM and MemtoReg+RegWrite+IF in WB. sw 4 cycles with MemWrite+IF in MEM, no RegWrite. instr_cnt=2, cycle_cnt=9.
- beq and j: inst=0x11090003 -> 3 cycles, Branch high in states 2-3, ALUOp=01 in EXEC, IF in EXEC. inst=0x08000005 -> 2 cycles, Jump and IF in DECODE.
- Illegal and stop: opcode 0x3F -> 2 cycles, illegal=1 and stays 1. Drop run during EXEC of an addi -> addi completes (WB with IF=1), then state=0.
- sortover mid-lw: assert sortover in MEM -> WB completes with IF=1, then HALT (6), outputs 0, counters frozen. Clr -> IDLE. With CNT_W=4, 20 R-types -> instr_cnt=15.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Bundles the instruction/run inputs and the decoded control outputs of the
// multi-cycle CPU control FSM into one port.
//   run, sortover, inst : driven by the CPU top / PC side
//   IF .. RegWrite      : per-state datapath enables and decoded control lines
//   illegal             : sticky unknown-opcode flag
//   state               : current FSM state encoding
//   instr_cnt/cycle_cnt : saturating performance counters
// master drives run/sortover/inst; slave is the controller itself.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             sortover;
  logic [31:0]      inst;
  logic             IF;
  logic             Branch;
  logic             Jump;
  logic             IR_en;
  logic             RegDst;
  logic             ALUSrc;
  logic [1:0]       ALUOp;
  logic             MemRead;
  logic             MemWrite;
  logic             MemtoReg;
  logic             RegWrite;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    output run, sortover, inst,
    input  IF, Branch, Jump, IR_en, RegDst, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, illegal, state, instr_cnt, cycle_cnt
  );

  modport slave (
    input  run, sortover, inst,
    output IF, Branch, Jump, IR_en, RegDst, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, illegal, state, instr_cnt, cycle_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS sort CPU. Each instruction walks
// FETCH -> DECODE -> EXEC -> MEM -> WB, skipping states its opcode does not
// need. The last state of every instruction raises IF so the PC advances.
// Ports:
//   Clk : rising-edge clock
//   Clr : asynchronous active-high reset
//   bus : multicycle_ctrl_if.slave (run/sortover/inst in, controls out)
// Control outputs are combinational from the state register and the latched
// opcode; counters saturate at 2^CNT_W-1.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  multicycle_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_q;
  logic [5:0]       op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] instr_q;
  logic [CNT_W-1:0] cycle_q;

  logic is_r, is_lw, is_sw, is_addi, is_br, is_j, is_ill;
  logic last_st, in_instr, in_alu;
  logic [1:0] alu_op;
  state_t end_next;

  // Only the opcode field matters to this controller.
  logic unused_inst;
  assign unused_inst = ^bus.inst[25:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign is_r    = (op_q == OP_R);
  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_addi = (op_q == OP_ADDI);
  assign is_br   = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign is_j    = (op_q == OP_J);
  assign is_ill  = !(is_r || is_lw || is_sw || is_addi || is_br || is_j);

  // Last state of the current instruction; this is exactly where IF fires.
  always_comb begin
    last_st = 1'b0;
    case (state_q)
      S_DECODE: last_st = is_j || is_ill;
      S_EXEC:   last_st = is_br;
      S_MEM:    last_st = is_sw;
      S_WB:     last_st = 1'b1;
      default:  last_st = 1'b0;
    endcase
  end

  // sortover outranks run when an instruction retires.
  always_comb begin
    if (bus.sortover)  end_next = S_HALT;
    else if (!bus.run) end_next = S_IDLE;
    else               end_next = S_FETCH;
  end

  assign in_instr = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC)  || (state_q == S_MEM) || (state_q == S_WB);
  assign in_alu   = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    alu_op = 2'b00;
    if (in_alu) begin
      if (is_r)       alu_op = 2'b10;
      else if (is_br) alu_op = 2'b01;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= S_IDLE;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
      instr_q   <= '0;
      cycle_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.run) state_q <= S_FETCH;
        S_FETCH: begin
          op_q    <= bus.inst[31:26];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_ill) illegal_q <= 1'b1;
          state_q <= last_st ? end_next : S_EXEC;
        end
        S_EXEC: begin
          if (last_st)             state_q <= end_next;
          else if (is_lw || is_sw) state_q <= S_MEM;
          else                     state_q <= S_WB;
        end
        S_MEM:    state_q <= last_st ? end_next : S_WB;
        S_WB:     state_q <= end_next;
        S_HALT:   state_q <= S_HALT;
        default:  state_q <= S_IDLE;
      endcase
      if (last_st)  instr_q <= sat_inc(instr_q);
      if (in_instr) cycle_q <= sat_inc(cycle_q);
    end
  end

  assign bus.IF        = last_st;
  assign bus.IR_en     = (state_q == S_FETCH);
  assign bus.Branch    = is_br && (state_q == S_DECODE || state_q == S_EXEC);
  assign bus.Jump      = is_j && (state_q == S_DECODE);
  assign bus.RegDst    = is_r && (state_q == S_WB);
  assign bus.ALUSrc    = (is_lw || is_sw || is_addi) && in_alu;
  assign bus.ALUOp     = alu_op;
  assign bus.MemRead   = is_lw && (state_q == S_MEM);
  assign bus.MemWrite  = is_sw && (state_q == S_MEM);
  assign bus.MemtoReg  = is_lw && (state_q == S_WB);
  assign bus.RegWrite  = (is_r || is_lw || is_addi) && (state_q == S_WB);
  assign bus.illegal   = illegal_q;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_q;
  assign bus.cycle_cnt = cycle_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle against hand-computed state/control tables, plus reset, stop, halt
// and counter saturation (CNT_W=4).
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;

  localparam logic [31:0] I_R    = 32'h012A4020;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090008;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_J    = 32'h08000005;
  localparam logic [31:0] I_ILL  = 32'hFC000000;
  localparam logic [31:0] I_ADDI = 32'h21090001;

  logic Clk = 1'b0;
  logic Clr;
  int   errors = 0;
  int   checks = 0;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  multicycle_ctrl #(.CNT_W(CNT_W)) dut (.Clk(Clk), .Clr(Clr), .bus(bus));

  always #5 Clk = ~Clk;

  // {IF,Branch,Jump,IR_en,RegDst,ALUSrc,ALUOp[1:0],MemRead,MemWrite,MemtoReg,RegWrite}
  logic [11:0] ctl;
  assign ctl = {bus.IF, bus.Branch, bus.Jump, bus.IR_en, bus.RegDst, bus.ALUSrc,
                bus.ALUOp, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite};

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Clr = 1'b1;
    bus.run = 1'b0;
    bus.sortover = 1'b0;
    bus.inst = 32'd0;
    @(negedge Clk);
    Clr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.state !== 3'd0 || ctl !== 12'h000 || bus.illegal !== 1'b0 ||
        bus.instr_cnt !== 4'd0 || bus.cycle_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset: state=%0d ctl=%h ill=%b ic=%0d cc=%0d required 0/000/0/0/0",
               bus.state, ctl, bus.illegal, bus.instr_cnt, bus.cycle_cnt);
    end
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++;
      if (bus.state !== 3'd0 || ctl !== 12'h000 || bus.cycle_cnt !== 4'd0) begin
        errors++;
        $display("FAIL idle_hold cyc%0d: state=%0d ctl=%h cc=%0d required 0/000/0",
                 k, bus.state, ctl, bus.cycle_cnt);
      end
    end
    // async clear in the middle of an instruction
    bus.inst = I_R;
    bus.run = 1'b1;
    cyc(); cyc(); cyc();
    Clr = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || ctl !== 12'h000 || bus.cycle_cnt !== 4'd0 ||
        bus.instr_cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_clr: state=%0d ctl=%h cc=%0d ic=%0d required 0/000/0/0",
               bus.state, ctl, bus.cycle_cnt, bus.instr_cnt);
    end
    @(negedge Clk);
    Clr = 1'b0;
  endtask

  task automatic test_rtype();
    logic [2:0]  es [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [11:0] ec [4] = '{12'h100, 12'h000, 12'h020, 12'h8A1};
    do_reset();
    bus.inst = I_R;
    bus.run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if (bus.state !== es[k] || ctl !== ec[k]) begin
        errors++;
        $display("FAIL rtype cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                 k, bus.state, ctl, es[k], ec[k]);
      end
      if (k == 2) bus.run = 1'b0;
    end
    cyc();
    checks++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== 4'd1 || bus.cycle_cnt !== 4'd4) begin
      errors++;
      $display("FAIL rtype_cnt: state=%0d ic=%0d cc=%0d required 0/1/4",
               bus.state, bus.instr_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_lw_sw();
    logic [2:0]  es [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [11:0] ec [9] = '{12'h100, 12'h000, 12'h040, 12'h048, 12'h843,
                            12'h100, 12'h000, 12'h040, 12'h844};
    do_reset();
    bus.inst = I_LW;
    bus.run = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      checks++;
      if (bus.state !== es[k] || ctl !== ec[k]) begin
        errors++;
        $display("FAIL lw_sw cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                 k, bus.state, ctl, es[k], ec[k]);
      end
      if (k == 4) bus.inst = I_SW;
      if (k == 7) bus.run = 1'b0;
    end
    cyc();
    checks++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== 4'd2 || bus.cycle_cnt !== 4'd9) begin
      errors++;
      $display("FAIL lw_sw_cnt: state=%0d ic=%0d cc=%0d required 0/2/9",
               bus.state, bus.instr_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_beq_j();
    logic [2:0]  es [5] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
    logic [11:0] ec [5] = '{12'h100, 12'h400, 12'hC10, 12'h100, 12'hA00};
    do_reset();
    bus.inst = I_BEQ;
    bus.run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (bus.state !== es[k] || ctl !== ec[k]) begin
        errors++;
        $display("FAIL beq_j cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                 k, bus.state, ctl, es[k], ec[k]);
      end
      if (k == 2) bus.inst = I_J;
      if (k == 3) bus.run = 1'b0;
    end
    cyc();
    checks++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== 4'd2 || bus.cycle_cnt !== 4'd5) begin
      errors++;
      $display("FAIL beq_j_cnt: state=%0d ic=%0d cc=%0d required 0/2/5",
               bus.state, bus.instr_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_illegal_stop();
    logic [2:0]  es [6] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd5};
    logic [11:0] ec [6] = '{12'h100, 12'h800, 12'h100, 12'h000, 12'h040, 12'h841};
    do_reset();
    bus.inst = I_ILL;
    bus.run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (bus.state !== es[k] || ctl !== ec[k]) begin
        errors++;
        $display("FAIL illegal_stop cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                 k, bus.state, ctl, es[k], ec[k]);
      end
      if (k == 1) bus.inst = I_ADDI;
      if (k == 2) begin
        checks++;
        if (bus.illegal !== 1'b1) begin
          errors++;
          $display("FAIL illegal_set: illegal=%b required 1", bus.illegal);
        end
      end
      if (k == 4) bus.run = 1'b0;
    end
    cyc();
    checks++;
    if (bus.state !== 3'd0 || bus.illegal !== 1'b1 || bus.instr_cnt !== 4'd2 ||
        bus.cycle_cnt !== 4'd6) begin
      errors++;
      $display("FAIL illegal_stop_end: state=%0d ill=%b ic=%0d cc=%0d required 0/1/2/6",
               bus.state, bus.illegal, bus.instr_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_sortover();
    logic [2:0]  es [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [11:0] ec [6] = '{12'h100, 12'h000, 12'h040, 12'h048, 12'h843, 12'h000};
    do_reset();
    bus.inst = I_LW;
    bus.run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if (bus.state !== es[k] || ctl !== ec[k]) begin
        errors++;
        $display("FAIL sortover cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                 k, bus.state, ctl, es[k], ec[k]);
      end
      if (k == 3) bus.sortover = 1'b1;
    end
    bus.sortover = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    checks++;
    if (bus.state !== 3'd6 || ctl !== 12'h000 || bus.instr_cnt !== 4'd1 ||
        bus.cycle_cnt !== 4'd5) begin
      errors++;
      $display("FAIL halt_hold: state=%0d ctl=%h ic=%0d cc=%0d required 6/000/1/5",
               bus.state, ctl, bus.instr_cnt, bus.cycle_cnt);
    end
    Clr = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== 4'd0 || bus.cycle_cnt !== 4'd0) begin
      errors++;
      $display("FAIL halt_clr: state=%0d ic=%0d cc=%0d required 0/0/0",
               bus.state, bus.instr_cnt, bus.cycle_cnt);
    end
    @(negedge Clk);
    Clr = 1'b0;
    bus.run = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.inst = I_R;
    bus.run = 1'b1;
    for (int k = 0; k < 80; k++) cyc();
    bus.run = 1'b0;
    cyc();
    checks++;
    if (bus.state !== 3'd0 || bus.instr_cnt !== 4'd15 || bus.cycle_cnt !== 4'd15) begin
      errors++;
      $display("FAIL saturation: state=%0d ic=%0d cc=%0d required 0/15/15",
               bus.state, bus.instr_cnt, bus.cycle_cnt);
    end
  endtask

  initial begin
    Clr = 1'b1;
    bus.run = 1'b0;
    bus.sortover = 1'b0;
    bus.inst = 32'd0;
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq_j();
    test_illegal_stop();
    test_sortover();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
